// File: rtl/iobus_initiator.sv
// iobus_initiator: OTTER IOBUS master. Accepts read / fill-write burst commands
// over a valid/ready port, drives registered IOBUS address/data/strobe, and
// returns one response beat per read word (or one beat-count response per write).
module iobus_initiator #(
    parameter int ADDR_STRIDE = 4,
    parameter int LEN_W       = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_WE,
    input  logic [31:0]      CMD_ADDR,
    input  logic [31:0]      CMD_WDATA,
    input  logic [LEN_W-1:0] CMD_LEN,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [31:0]      RSP_DATA,
    output logic             RSP_LAST,
    output logic             BUSY,
    output logic [31:0]      IOBUS_ADDR,
    output logic [31:0]      IOBUS_OUT,
    output logic             IOBUS_WR,
    input  logic [31:0]      IOBUS_IN
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        iobus_addr_q, iobus_addr_d;
    logic [31:0]        iobus_out_q, iobus_out_d;
    logic               iobus_wr_q, iobus_wr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_last_q, rsp_last_d;
    logic               cmd_ready_q, cmd_ready_d;

    // Wrapping address step; 32-bit add drops the carry so 0xFFFFFFFC+4 -> 0.
    logic [31:0] next_addr;
    assign next_addr = iobus_addr_q + 32'(ADDR_STRIDE);

    // Next-state and next-output computation for the burst FSM.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        len_d        = len_q;
        beat_d       = beat_q;
        wdata_d      = wdata_q;
        iobus_addr_d = iobus_addr_q;
        iobus_out_d  = iobus_out_q;
        iobus_wr_d   = iobus_wr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_last_d   = rsp_last_q;

        case (state_q)
            ST_IDLE: begin
                iobus_wr_d = 1'b0;
                if (CMD_VALID && cmd_ready_q) begin
                    we_d         = CMD_WE;
                    len_d        = CMD_LEN;
                    wdata_d      = CMD_WDATA;
                    iobus_addr_d = CMD_ADDR;
                    beat_d       = '0;
                    state_d      = ST_BUS;
                    // Write strobe for beat 0 is registered here so the
                    // strobes run back-to-back starting the next cycle.
                    if (CMD_WE) begin
                        iobus_wr_d  = 1'b1;
                        iobus_out_d = CMD_WDATA;
                    end
                end
            end

            ST_BUS: begin
                if (we_q) begin
                    if (beat_q == len_q) begin
                        iobus_wr_d  = 1'b0;
                        // Count is LEN+1 in 32 bits so a full 2**LEN_W burst is not truncated.
                        rsp_data_d  = 32'(len_q) + 32'd1;
                        rsp_last_d  = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RSP;
                    end else begin
                        beat_d       = beat_q + LEN_W'(1);
                        iobus_addr_d = next_addr;
                        iobus_out_d  = wdata_q;
                        iobus_wr_d   = 1'b1;
                    end
                end else begin
                    rsp_data_d  = IOBUS_IN;
                    rsp_last_d  = (beat_q == len_q);
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end

            ST_RSP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d       = beat_q + LEN_W'(1);
                        iobus_addr_d = next_addr;
                        state_d      = ST_BUS;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                iobus_wr_d  = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        // Ready only once actually sitting in IDLE, so the edge that returns
        // to IDLE never also accepts a command.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset aborts any burst immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            len_q        <= '0;
            beat_q       <= '0;
            wdata_q      <= '0;
            iobus_addr_q <= '0;
            iobus_out_q  <= '0;
            iobus_wr_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
            cmd_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            wdata_q      <= wdata_d;
            iobus_addr_q <= iobus_addr_d;
            iobus_out_q  <= iobus_out_d;
            iobus_wr_q   <= iobus_wr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_last_q   <= rsp_last_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign CMD_READY  = cmd_ready_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_DATA   = rsp_data_q;
    assign RSP_LAST   = rsp_last_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign IOBUS_ADDR = iobus_addr_q;
    assign IOBUS_OUT  = iobus_out_q;
    assign IOBUS_WR   = iobus_wr_q;

endmodule
